// File: rtl/hazard_detection_unit_if.sv
// Hazard detection unit bundle: ID-stage instruction info and the EX branch
// outcome flow into the unit; front-end stall/flush controls and the event
// counters flow out of it.
//
//   master : pipeline side (drives ID fields and branch outcome, reads controls)
//   slave  : hazard detection unit (reads ID fields, drives controls/counters)
//
//   id_valid_i        ID stage holds a real instruction
//   id_rs_i/id_rt_i   ID source registers
//   id_use_rs_i/rt_i  ID instruction actually reads rs / rt
//   id_rd_i           ID destination register (already muxed rt/rd)
//   id_regwrite_i     ID instruction writes the register file
//   id_memread_i      ID instruction is a load
//   ex_branch_taken_i branch in EX resolved taken this cycle
//   pc_write_o        PC update enable
//   ifid_write_o      IF/ID write enable
//   ifid_flush_o      zero IF/ID on the next edge
//   idex_flush_o      bubble into ID/EX on the next edge
//   stall_cnt_o       saturating count of load-use stall cycles
//   flush_cnt_o       saturating count of taken-branch flushes
interface hazard_detection_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              ex_branch_taken_i;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_rd_i,
    output id_regwrite_i, id_memread_i, ex_branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
    input  stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, id_rd_i,
    input  id_regwrite_i, id_memread_i, ex_branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
    output stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection unit for the 5-stage MIPS pipeline.
//
// Keeps a shadow copy of the destination info of the instructions in EX and
// MEM. Stalls the front end for one cycle on a load-use hazard that
// forwarding cannot cover (load in EX feeding the ID instruction), and flushes
// IF/ID and ID/EX when a branch in EX resolves taken. Two saturating counters
// record stall cycles and flush events.
//
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   hz     hazard_detection_unit_if.slave (ID info in, controls/counters out)
//
// Hazard controls are combinational from the current ID inputs; shadow state
// and counters update on the next edge.
module hazard_detection_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic                    clk_i,
  input logic                    rst_i,
  hazard_detection_unit_if.slave hz
);

  typedef enum logic {StIdle, StStall} state_e;

  state_e            state_q, state_d;

  // EX shadow
  logic              ex_v_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_rw_q;
  logic              ex_mr_q;
  // MEM shadow
  logic              mem_v_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_rw_q;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              rs_match;
  logic              rt_match;
  logic              luse;
  logic              stall;
  logic              flush;
  logic              bubble;

  // Load-use: only a load in EX matters. A load one step further (MEM) is
  // covered by forwarding, so the MEM shadow never takes part here.
  always_comb begin
    rs_match = hz.id_use_rs_i && (hz.id_rs_i == ex_rd_q);
    rt_match = hz.id_use_rt_i && (hz.id_rt_i == ex_rd_q);
    luse     = hz.id_valid_i && ex_v_q && ex_mr_q && ex_rw_q && (ex_rd_q != '0) &&
               (rs_match || rt_match);
  end

  // A taken branch discards the ID instruction anyway, so it overrides the
  // stall. Gating on StIdle makes the one-cycle bound explicit: the bubble
  // that follows a stall can never re-trigger it.
  always_comb begin
    flush  = !rst_i && hz.ex_branch_taken_i;
    stall  = !rst_i && luse && !hz.ex_branch_taken_i && (state_q == StIdle);
    bubble = stall || flush;
  end

  always_comb begin
    hz.pc_write_o   = !stall;
    hz.ifid_write_o = !stall;
    hz.ifid_flush_o = flush;
    hz.idex_flush_o = bubble;
    hz.stall_cnt_o  = stall_cnt_q;
    hz.flush_cnt_o  = flush_cnt_q;
  end

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = stall ? StStall : StIdle;
      StStall: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ex_v_q      <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      mem_rw_q <= ex_rw_q;

      // Bubbles are fully zeroed so a stale rd can never alias a real match.
      if (bubble || !hz.id_valid_i) begin
        ex_v_q  <= 1'b0;
        ex_rd_q <= '0;
        ex_rw_q <= 1'b0;
        ex_mr_q <= 1'b0;
      end else begin
        ex_v_q  <= 1'b1;
        ex_rd_q <= hz.id_rd_i;
        ex_rw_q <= hz.id_regwrite_i;
        ex_mr_q <= hz.id_memread_i;
      end

      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Invalid shadow entries must be all-zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (ex_v_q || (!ex_rw_q && !ex_mr_q && (ex_rd_q == '0)));
      assert (mem_v_q || (!mem_rw_q && (mem_rd_q == '0)));
    end
  end

endmodule
